vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Single-port video RAM arbiter sharing the 128 KB VRAM between the display fetch engine and the two CPU data ports behind the 6502 bus interface. Runs entirely in the `clk25` domain. Grants one RAM access per cycle, sequences fixed-length display bursts, and routes read data back to the issuing requester.

## Interface
Parameters:
- `ADDR_W`, 17: byte address width. The word address is `ADDR_W-2` bits.
- `DISP_BURST`, 4: 32-bit words per display grant. Range 1..16.

Ports:
- `clk25`  in  1  system clock, 25 MHz
- `res_n`  in  1  reset; one clock, synchronous, active-low
- `disp_req`  in  1  display request; level, held until ack
- `disp_addr`  in  ADDR_W-2  burst start word address
- `disp_ack`  out  1  one-cycle pulse: burst started
- `disp_rvalid`  out  1  read word valid
- `disp_rdata`  out  32  read word
- `cpuN_req`  in  1  CPU port N (N=0,1) request; level, held until ack
- `cpuN_we`  in  1  1 = write, 0 = read
- `cpuN_addr`  in  ADDR_W  byte address
- `cpuN_wdata`  in  8  write byte
- `cpuN_ack`  out  1  one-cycle pulse: access issued
- `cpuN_rvalid`  out  1  read byte valid
- `cpuN_rdata`  out  8  read byte
- `ram_addr`  out  ADDR_W-2  word address
- `ram_we`  out  1  write strobe
- `ram_wrbytesel`  out  4  byte-lane enables
- `ram_wrdata`  out  32  write data
- `ram_rddata`  in  32  read data; valid one cycle after address is presented

## Operation
- Two states:
  - IDLE: arbitrates every cycle.
  - BURST: issues display words; CPU requests wait.
- Eligibility: a requester acked in cycle N is ineligible for the decision made in cycle N. Each CPU port therefore gets at most one access per 2 cycles.
- IDLE priority:
  - Eligible display request wins.
  - Exception: if the previous state was BURST and any CPU request is pending, the CPU gets the slot. This guarantees CPU progress.
  - Among CPU ports, a round-robin pointer decides. The pointer resets to cpu0 and moves to the other port after each CPU grant.
- Display grant with `DISP_BURST` > 1:
  - Enter BURST. Issue words `disp_addr`, +1, … one per cycle.
  - The address wraps modulo 2^(ADDR_W-2).
  - The last word returns to IDLE. `disp_ack` pulses only on the first word.
- CPU write:
  - `ram_wrbytesel` is one-hot on `addr[1:0]`.
  - `ram_wrdata` carries the byte replicated ×4.
  - `ram_we` is high.
  - No rvalid.
- CPU read: the byte selected by the registered `addr[1:0]` is extracted from `ram_rddata`.
- Idle cycle (no grant): `ram_we`=0, `ram_wrbytesel`=0, `ram_addr` holds its last value.
- Reset values: all acks, rvalids and `ram_we` are 0; `ram_wrbytesel`=0; `ram_addr`=0; rdata outputs are 0; state is IDLE; pointer is cpu0.
- Reset mid-burst or mid-read aborts the operation. In-flight rvalids are dropped and no rvalid appears after reset releases.

## Timing
- Request high before edge E is sampled at E. `ack` and `ram_*` are registered and valid during cycle E..E+1.
- RAM returns data in cycle E+1..E+2. It is captured at E+2, so `rvalid`/`rdata` are high during E+2..E+3.
- Read latency is 2 cycles from ack.
- Burst word k (k=0..DISP_BURST-1) is issued in cycle E+k and returns in cycle E+2+k, giving back-to-back `disp_rvalid`.
- Simultaneous events:
  - New display request arriving during BURST: waits, and the CPU is served first if pending.
  - Simultaneous `cpu0`/`cpu1` requests: resolved by the pointer.
- A requester may drop or change its request in the cycle after ack.

## Configuration
- `VRAM_ARB_RR_EN` defined: CPU ports use round-robin as above.
- Not defined: fixed priority, cpu0 over cpu1. The pointer register is not built. cpu1 may starve only while cpu0 requests every eligible slot.

## Structure
- Package `vram_arb_pkg`:
  - state encoding (IDLE, BURST)
  - requester-ID encoding (NONE, DISP, CPU0, CPU1)
  - byte-lane one-hot decode function
- Sub-module `vram_arb_rdpipe`: a 2-stage pipeline of requester ID plus byte offset. It routes `ram_rddata` to the correct rvalid/rdata and performs the byte extraction.

## Test plan
- Reset: hold `res_n`=0 for 3 cycles with all reqs high -> all outputs 0. First ack appears on the cycle after release, to display.
- cpu0 write of 0x5A to byte 0x00013 -> `ram_addr`=0x0004, `ram_wrbytesel`=4'b1000, `ram_wrdata`=0x5A5A5A5A, `cpu0_ack` pulse, no `cpu0_rvalid`.
- cpu1 read of 0x00006 with RAM word 0x11223344 -> `cpu1_rvalid` 2 cycles after ack, `cpu1_rdata`=0x22.
- Display burst at 0x7FFE with `DISP_BURST`=4 -> `ram_addr` 0x7FFE, 0x7FFF, 0x0000, 0x0001 on consecutive cycles; four consecutive `disp_rvalid`; a pending `cpu0_req` is acked in the cycle right after the burst.
- cpu0 and cpu1 requesting continuously -> acks alternate 0,1,0,1 with `VRAM_ARB_RR_EN`; without it, only cpu0 is acked in each eligible slot, and cpu1 only in cpu0's ineligible slot.
- Reset asserted during burst word 2 -> no further `disp_rvalid`; state is IDLE after release.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared types and helpers for the VRAM arbiter: FSM states, requester IDs and
// the write byte-lane decode.
package vram_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    ID_NONE = 2'd0,
    ID_DISP = 2'd1,
    ID_CPU0 = 2'd2,
    ID_CPU1 = 2'd3
  } req_id_t;

  // Lane k of a 32-bit word holds byte address offset k (little-endian).
  function automatic logic [3:0] lane_onehot(input logic [1:0] off);
    lane_onehot = 4'b0001 << off;
  endfunction

endpackage

// File: rtl/vram_arb_rdpipe.sv
// Read-return pipeline: carries the issuing requester and byte offset alongside
// the RAM access and steers ram_rddata to the matching rvalid/rdata outputs.
module vram_arb_rdpipe
  import vram_arb_pkg::*;
(
  input  logic        clk25,
  input  logic        res_n,
  input  req_id_t     rd_id,
  input  logic [1:0]  rd_off,
  input  logic [31:0] ram_rddata,
  output logic        disp_rvalid,
  output logic [31:0] disp_rdata,
  output logic        cpu0_rvalid,
  output logic [7:0]  cpu0_rdata,
  output logic        cpu1_rvalid,
  output logic [7:0]  cpu1_rdata
);

  req_id_t    id_p0;
  logic [1:0] off_p0;

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] off);
    logic [31:0] shifted;
    shifted   = word >> {off, 3'b000};
    lane_byte = shifted[7:0];
  endfunction

  always_ff @(posedge clk25) begin
    if (!res_n) begin
      id_p0       <= ID_NONE;
      off_p0      <= '0;
      disp_rvalid <= 1'b0;
      cpu0_rvalid <= 1'b0;
      cpu1_rvalid <= 1'b0;
      disp_rdata  <= '0;
      cpu0_rdata  <= '0;
      cpu1_rdata  <= '0;
    end else begin
      // p0: address is at the RAM, data arrives during this stage
      id_p0       <= rd_id;
      off_p0      <= rd_off;
      // p1: capture returned word for the owner of the access
      disp_rvalid <= (id_p0 == ID_DISP);
      cpu0_rvalid <= (id_p0 == ID_CPU0);
      cpu1_rvalid <= (id_p0 == ID_CPU1);
      if (id_p0 == ID_DISP) disp_rdata <= ram_rddata;
      if (id_p0 == ID_CPU0) cpu0_rdata <= lane_byte(ram_rddata, off_p0);
      if (id_p0 == ID_CPU1) cpu1_rdata <= lane_byte(ram_rddata, off_p0);
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter for display bursts and two CPU byte ports.
// Define VRAM_ARB_RR_EN for round-robin between CPU ports; otherwise cpu0 has fixed priority.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int DISP_BURST = 4
) (
  input  logic              clk25,
  input  logic              res_n,
  input  logic              disp_req,
  input  logic [ADDR_W-3:0] disp_addr,
  output logic              disp_ack,
  output logic              disp_rvalid,
  output logic [31:0]       disp_rdata,
  input  logic              cpu0_req,
  input  logic              cpu0_we,
  input  logic [ADDR_W-1:0] cpu0_addr,
  input  logic [7:0]        cpu0_wdata,
  output logic              cpu0_ack,
  output logic              cpu0_rvalid,
  output logic [7:0]        cpu0_rdata,
  input  logic              cpu1_req,
  input  logic              cpu1_we,
  input  logic [ADDR_W-1:0] cpu1_addr,
  input  logic [7:0]        cpu1_wdata,
  output logic              cpu1_ack,
  output logic              cpu1_rvalid,
  output logic [7:0]        cpu1_rdata,
  output logic [ADDR_W-3:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_wrbytesel,
  output logic [31:0]       ram_wrdata,
  input  logic [31:0]       ram_rddata
);

  localparam int WA_W  = ADDR_W - 2;
  localparam int CNT_W = 4;

  arb_state_t        state;
  logic              from_burst;
  logic [CNT_W-1:0]  burst_cnt;
  req_id_t           rd_id;
  logic [1:0]        rd_off;

  logic              disp_elig;
  logic              cpu0_elig;
  logic              cpu1_elig;
  logic              pick_cpu1;
  req_id_t           gnt;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_wdata;

  // A requester acked last cycle may still show its request; it sits this decision out.
  assign disp_elig = disp_req && !disp_ack;
  assign cpu0_elig = cpu0_req && !cpu0_ack;
  assign cpu1_elig = cpu1_req && !cpu1_ack;

`ifdef VRAM_ARB_RR_EN
  logic rr_ptr;

  always_ff @(posedge clk25) begin
    if (!res_n)                rr_ptr <= 1'b0;
    else if (gnt == ID_CPU0)   rr_ptr <= 1'b1;
    else if (gnt == ID_CPU1)   rr_ptr <= 1'b0;
  end
`endif

  always_comb begin
    gnt = ID_NONE;
`ifdef VRAM_ARB_RR_EN
    pick_cpu1 = cpu1_elig && (!cpu0_elig || rr_ptr);
`else
    pick_cpu1 = cpu1_elig && !cpu0_elig;
`endif
    if (state == ST_IDLE) begin
      // Right after a burst a waiting CPU goes first so back-to-back bursts cannot starve it.
      if (disp_elig && !(from_burst && (cpu0_elig || cpu1_elig)))
        gnt = ID_DISP;
      else if (cpu0_elig || cpu1_elig)
        gnt = pick_cpu1 ? ID_CPU1 : ID_CPU0;
    end
  end

  assign sel_we    = (gnt == ID_CPU1) ? cpu1_we    : cpu0_we;
  assign sel_addr  = (gnt == ID_CPU1) ? cpu1_addr  : cpu0_addr;
  assign sel_wdata = (gnt == ID_CPU1) ? cpu1_wdata : cpu0_wdata;

  always_ff @(posedge clk25) begin
    if (!res_n) begin
      state         <= ST_IDLE;
      from_burst    <= 1'b0;
      burst_cnt     <= '0;
      disp_ack      <= 1'b0;
      cpu0_ack      <= 1'b0;
      cpu1_ack      <= 1'b0;
      ram_addr      <= '0;
      ram_we        <= 1'b0;
      ram_wrbytesel <= '0;
      ram_wrdata    <= '0;
      rd_id         <= ID_NONE;
      rd_off        <= '0;
    end else begin
      disp_ack      <= (gnt == ID_DISP);
      cpu0_ack      <= (gnt == ID_CPU0);
      cpu1_ack      <= (gnt == ID_CPU1);
      ram_we        <= 1'b0;
      ram_wrbytesel <= '0;
      rd_id         <= ID_NONE;
      from_burst    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt == ID_DISP) begin
            ram_addr <= disp_addr;
            rd_id    <= ID_DISP;
            rd_off   <= '0;
            if (DISP_BURST > 1) begin
              state     <= ST_BURST;
              burst_cnt <= CNT_W'(DISP_BURST - 1);
            end
          end else if (gnt != ID_NONE) begin
            ram_addr <= sel_addr[ADDR_W-1:2];
            rd_off   <= sel_addr[1:0];
            if (sel_we) begin
              ram_we        <= 1'b1;
              ram_wrbytesel <= lane_onehot(sel_addr[1:0]);
              ram_wrdata    <= {4{sel_wdata}};
            end else begin
              rd_id <= gnt;
            end
          end
        end
        ST_BURST: begin
          // Word address wraps naturally at the top of VRAM.
          ram_addr  <= ram_addr + WA_W'(1);
          rd_id     <= ID_DISP;
          rd_off    <= '0;
          burst_cnt <= burst_cnt - CNT_W'(1);
          if (burst_cnt == CNT_W'(1)) begin
            state      <= ST_IDLE;
            from_burst <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  vram_arb_rdpipe u_rdpipe (
    .clk25       (clk25),
    .res_n       (res_n),
    .rd_id       (rd_id),
    .rd_off      (rd_off),
    .ram_rddata  (ram_rddata),
    .disp_rvalid (disp_rvalid),
    .disp_rdata  (disp_rdata),
    .cpu0_rvalid (cpu0_rvalid),
    .cpu0_rdata  (cpu0_rdata),
    .cpu1_rvalid (cpu1_rvalid),
    .cpu1_rdata  (cpu1_rdata)
  );

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: reset, display burst with wrap, CPU write/read,
// CPU alternation, pointer behaviour and reset during a burst.
module tb_vram_arbiter;

  logic        clk25 = 1'b0;
  logic        res_n;
  logic        disp_req;
  logic [14:0] disp_addr;
  logic        disp_ack, disp_rvalid;
  logic [31:0] disp_rdata;
  logic        cpu0_req, cpu0_we, cpu0_ack, cpu0_rvalid;
  logic [16:0] cpu0_addr;
  logic [7:0]  cpu0_wdata, cpu0_rdata;
  logic        cpu1_req, cpu1_we, cpu1_ack, cpu1_rvalid;
  logic [16:0] cpu1_addr;
  logic [7:0]  cpu1_wdata, cpu1_rdata;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [3:0]  ram_wrbytesel;
  logic [31:0] ram_wrdata;
  logic [31:0] ram_rddata = 32'h0;

  int total = 0;
  int bad   = 0;

  always #20 clk25 = ~clk25;

  vram_arbiter dut (
    .clk25(clk25), .res_n(res_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .cpu0_req(cpu0_req), .cpu0_we(cpu0_we), .cpu0_addr(cpu0_addr), .cpu0_wdata(cpu0_wdata),
    .cpu0_ack(cpu0_ack), .cpu0_rvalid(cpu0_rvalid), .cpu0_rdata(cpu0_rdata),
    .cpu1_req(cpu1_req), .cpu1_we(cpu1_we), .cpu1_addr(cpu1_addr), .cpu1_wdata(cpu1_wdata),
    .cpu1_ack(cpu1_ack), .cpu1_rvalid(cpu1_rvalid), .cpu1_rdata(cpu1_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wrbytesel(ram_wrbytesel),
    .ram_wrdata(ram_wrdata), .ram_rddata(ram_rddata)
  );

  // RAM contents: word 1 holds 0x11223344, every other word is 0xD0000000 | address.
  function automatic logic [31:0] ram_word(input logic [14:0] a);
    ram_word = (a == 15'd1) ? 32'h11223344 : (32'hD000_0000 | {17'd0, a});
  endfunction

  always @(posedge clk25) ram_rddata <= ram_word(ram_addr);

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    res_n = 1'b0;
    disp_req = 1'b1; disp_addr = 15'h7FFE;
    cpu0_req = 1'b1; cpu0_we = 1'b1; cpu0_addr = 17'h00013; cpu0_wdata = 8'h5A;
    cpu1_req = 1'b1; cpu1_we = 1'b0; cpu1_addr = 17'h00006; cpu1_wdata = 8'h00;

    tick(); tick(); tick();
    chk("rst_acks",    32'({disp_ack, cpu0_ack, cpu1_ack}), 32'd0);
    chk("rst_rvalids", 32'({disp_rvalid, cpu0_rvalid, cpu1_rvalid}), 32'd0);
    chk("rst_ram_ctl", 32'({ram_we, ram_wrbytesel}), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_wrdata",  ram_wrdata, 32'd0);
    chk("rst_rdata",   disp_rdata | 32'({cpu0_rdata, cpu1_rdata}), 32'd0);

    // Release: display wins first, burst at 0x7FFE wraps through 0
    res_n = 1'b1;
    tick();
    chk("e0_disp_ack", 32'(disp_ack), 32'd1);
    chk("e0_cpu_acks", 32'({cpu0_ack, cpu1_ack}), 32'd0);
    chk("e0_addr", 32'(ram_addr), 32'h7FFE);
    disp_req = 1'b0;
    tick();
    chk("e1_disp_ack", 32'(disp_ack), 32'd0);
    chk("e1_addr", 32'(ram_addr), 32'h7FFF);
    chk("e1_cpu0_wait", 32'(cpu0_ack), 32'd0);
    tick();
    chk("e2_addr", 32'(ram_addr), 32'h0000);
    chk("e2_rvalid", 32'(disp_rvalid), 32'd1);
    chk("e2_rdata", disp_rdata, 32'hD0007FFE);
    tick();
    chk("e3_addr", 32'(ram_addr), 32'h0001);
    chk("e3_rvalid", 32'(disp_rvalid), 32'd1);
    chk("e3_rdata", disp_rdata, 32'hD0007FFF);

    // cpu0 write right after the burst
    tick();
    chk("e4_cpu0_ack", 32'(cpu0_ack), 32'd1);
    chk("e4_cpu1_ack", 32'(cpu1_ack), 32'd0);
    chk("e4_addr", 32'(ram_addr), 32'h0004);
    chk("e4_we", 32'(ram_we), 32'd1);
    chk("e4_bytesel", 32'(ram_wrbytesel), 32'h8);
    chk("e4_wrdata", ram_wrdata, 32'h5A5A5A5A);
    chk("e4_rvalid", 32'(disp_rvalid), 32'd1);
    chk("e4_rdata", disp_rdata, 32'hD0000000);
    cpu0_req = 1'b0;

    // cpu1 read of byte 0x00006
    tick();
    chk("e5_cpu1_ack", 32'(cpu1_ack), 32'd1);
    chk("e5_cpu0_ack", 32'(cpu0_ack), 32'd0);
    chk("e5_addr", 32'(ram_addr), 32'h0001);
    chk("e5_ctl", 32'({ram_we, ram_wrbytesel}), 32'd0);
    chk("e5_rdata", disp_rdata, 32'h11223344);
    cpu1_req = 1'b0;
    tick();
    chk("e6_idle_ctl", 32'({ram_we, ram_wrbytesel}), 32'd0);
    chk("e6_addr_hold", 32'(ram_addr), 32'h0001);
    chk("e6_no_wr_rvalid", 32'({disp_rvalid, cpu0_rvalid}), 32'd0);
    tick();
    chk("e7_cpu1_rvalid", 32'(cpu1_rvalid), 32'd1);
    chk("e7_cpu1_rdata", 32'(cpu1_rdata), 32'h22);
    tick();
    chk("e8_cpu1_rvalid", 32'(cpu1_rvalid), 32'd0);

    // Both CPUs requesting continuously: acks alternate
    cpu0_we = 1'b0; cpu0_addr = 17'h0000B;
    cpu0_req = 1'b1; cpu1_req = 1'b1;
    tick();
    chk("f0_acks", 32'({cpu0_ack, cpu1_ack}), 32'b10);
    tick();
    chk("f1_acks", 32'({cpu0_ack, cpu1_ack}), 32'b01);
    tick();
    chk("f2_acks", 32'({cpu0_ack, cpu1_ack}), 32'b10);
    chk("f2_cpu0_rvalid", 32'(cpu0_rvalid), 32'd1);
    chk("f2_cpu0_rdata", 32'(cpu0_rdata), 32'hD0);
    tick();
    chk("f3_acks", 32'({cpu0_ack, cpu1_ack}), 32'b01);
    chk("f3_cpu1_rvalid", 32'(cpu1_rvalid), 32'd1);
    chk("f3_cpu1_rdata", 32'(cpu1_rdata), 32'h22);
    cpu0_req = 1'b0; cpu1_req = 1'b0;
    tick();
    chk("f4_acks", 32'({cpu0_ack, cpu1_ack}), 32'd0);
    chk("f4_cpu0_rvalid", 32'(cpu0_rvalid), 32'd1);
    tick();
    chk("f5_cpu1_rvalid", 32'(cpu1_rvalid), 32'd1);

    // Lone cpu0 grant, then both request together
    cpu0_req = 1'b1;
    tick();
    chk("g0_cpu0_ack", 32'(cpu0_ack), 32'd1);
    cpu0_req = 1'b0;
    tick();
    chk("g1_idle", 32'({cpu0_ack, cpu1_ack}), 32'd0);
    cpu0_req = 1'b1; cpu1_req = 1'b1;
    tick();
`ifdef VRAM_ARB_RR_EN
    chk("g2_rr_acks", 32'({cpu0_ack, cpu1_ack}), 32'b01);
`else
    chk("g2_fixed_acks", 32'({cpu0_ack, cpu1_ack}), 32'b10);
`endif
    cpu0_req = 1'b0; cpu1_req = 1'b0;
    tick(); tick(); tick();

    // Reset during burst word 2 drops in-flight returns
    disp_addr = 15'h0010; disp_req = 1'b1;
    tick();
    chk("h0_disp_ack", 32'(disp_ack), 32'd1);
    chk("h0_addr", 32'(ram_addr), 32'h0010);
    disp_req = 1'b0;
    tick();
    chk("h1_addr", 32'(ram_addr), 32'h0011);
    tick();
    chk("h2_addr", 32'(ram_addr), 32'h0012);
    chk("h2_rvalid", 32'(disp_rvalid), 32'd1);
    chk("h2_rdata", disp_rdata, 32'hD0000010);
    res_n = 1'b0;
    tick();
    chk("h3_rst_rvalid", 32'(disp_rvalid), 32'd0);
    chk("h3_rst_addr", 32'(ram_addr), 32'd0);
    chk("h3_rst_rdata", disp_rdata, 32'd0);
    res_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("h_post_rst_rvalid", 32'(disp_rvalid), 32'd0);
      chk("h_post_rst_idle", 32'({ram_we, disp_ack}), 32'd0);
    end
    cpu0_req = 1'b1;
    tick();
    chk("h7_cpu0_ack", 32'(cpu0_ack), 32'd1);
    chk("h7_addr", 32'(ram_addr), 32'h0002);
    cpu0_req = 1'b0;
    tick(); tick();
    chk("h9_cpu0_rvalid", 32'(cpu0_rvalid), 32'd1);
    chk("h9_cpu0_rdata", 32'(cpu0_rdata), 32'hD0);
    chk("h9_disp_rvalid", 32'(disp_rvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
